fre_meas_ctrl: RTL



---
 rtl/fre_meas_ctrl_if.sv | 24 ++
 rtl/fre_meas_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fre_meas_ctrl_if.sv
// Judge handshake and result bus for fre_meas_ctrl.
// master = the measurement controller, slave = judge / result consumer side.
interface fre_meas_ctrl_if #(
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned OUT_WIDTH = 24
) ();
  logic                 judge_start;
  logic [IN_WIDTH-1:0]  judge_fre;
  logic                 judge_dready;
  logic [OUT_WIDTH-1:0] freq;
  logic                 freq_valid;
  logic                 busy;
  logic                 meas_err;

  modport master (
    output judge_start, freq, freq_valid, busy, meas_err,
    input  judge_fre, judge_dready
  );

  modport slave (
    input  judge_start, freq, freq_valid, busy, meas_err,
    output judge_fre, judge_dready
  );
endinterface

// File: rtl/fre_meas_ctrl.sv
// Sequences the edge-width judge, averages 2^AVG_LOG half-period widths and divides to Hz.
// Optional macro FRE_MEAS_OUTLIER_REJ_EN: reject samples deviating more than ref/8 from the round's first sample.
module fre_meas_ctrl #(
  parameter int unsigned IN_WIDTH    = 18,
  parameter int unsigned OUT_WIDTH   = 24,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned AVG_LOG     = 2,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000,
  parameter logic [3:0]  MAX_RETRY   = 4'd7,
  parameter int unsigned DIV_W       = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  fre_meas_ctrl_if.master bus
);

  localparam int unsigned SUM_W  = IN_WIDTH + AVG_LOG;
  localparam int unsigned CNT_W  = AVG_LOG + 1;
  localparam int unsigned DCNT_W = $clog2(DIV_W);
  localparam logic [DIV_W-1:0]  DIVIDEND = DIV_W'(CLK_HZ) << AVG_LOG;
  localparam logic [CNT_W-1:0]  LAST_SMP = CNT_W'((1 << AVG_LOG) - 1);
  localparam logic [DCNT_W-1:0] LAST_BIT = DCNT_W'(DIV_W - 1);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ARM  = 5'b00010,
    S_WAIT = 5'b00100,
    S_DIV  = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  state_e               state_q, state_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [3:0]           retry_q, retry_d;
  logic [31:0]          tmo_q, tmo_d;
  logic [DIV_W-1:0]     rem_q, rem_d;
  logic [DIV_W-1:0]     quo_q, quo_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic                 judge_start_q, judge_start_d;
  logic [OUT_WIDTH-1:0] freq_q, freq_d;
  logic                 freq_valid_q, freq_valid_d;
  logic                 busy_q, busy_d;
  logic                 meas_err_q, meas_err_d;

  logic                 outlier;
  logic                 accept;
  logic [DIV_W:0]       rem_sh;
  logic [DIV_W:0]       divisor;
  logic [3:0]           retry_inc;

`ifdef FRE_MEAS_OUTLIER_REJ_EN
  logic [IN_WIDTH-1:0]  ref_q, ref_d;
  logic [IN_WIDTH-1:0]  dev;

  // Deviation from the round's reference sample; the first sample is never an outlier.
  always_comb begin
    dev     = (bus.judge_fre >= ref_q) ? (bus.judge_fre - ref_q) : (ref_q - bus.judge_fre);
    outlier = (smp_cnt_q != '0) && (dev > (ref_q >> 3));
    ref_d   = ref_q;
    if (accept && (smp_cnt_q == '0)) begin
      ref_d = bus.judge_fre;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_d;
    end
  end
`else
  assign outlier = 1'b0;
`endif

  assign accept    = (state_q == S_WAIT) && bus.judge_dready && (bus.judge_fre != '0) && !outlier;
  assign rem_sh    = {rem_q, quo_q[DIV_W-1]};
  assign divisor   = (DIV_W+1)'({sum_q, 1'b0});
  assign retry_inc = retry_q + 4'd1;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    smp_cnt_d    = smp_cnt_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dcnt_d       = dcnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    meas_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sum_d     = '0;
        smp_cnt_d = '0;
        retry_d   = '0;
        if (en) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        tmo_d   = TIMEOUT_CYC;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q - 32'd1;
        if (accept) begin
          sum_d     = sum_q + SUM_W'(bus.judge_fre);
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          retry_d   = '0;
          if (smp_cnt_q == LAST_SMP) begin
            rem_d   = '0;
            quo_d   = DIVIDEND;
            dcnt_d  = '0;
            state_d = S_DIV;
          end else begin
            state_d = S_ARM;
          end
        end else if (bus.judge_dready || (tmo_q == '0)) begin
          if (retry_inc == MAX_RETRY) begin
            meas_err_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            retry_d = retry_inc;
            state_d = S_ARM;
          end
        end
      end
      S_DIV: begin
        // Restoring step: remainder always stays below the divisor, so DIV_W bits suffice.
        if (rem_sh >= divisor) begin
          rem_d = DIV_W'(rem_sh - divisor);
          quo_d = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DIV_W-1:0];
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        dcnt_d = dcnt_q + DCNT_W'(1);
        if (dcnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (|quo_q[DIV_W-1:OUT_WIDTH]) begin
          freq_d = '1;
        end else begin
          freq_d = quo_q[OUT_WIDTH-1:0];
        end
        freq_valid_d = 1'b1;
        sum_d        = '0;
        smp_cnt_d    = '0;
        retry_d      = '0;
        state_d      = en ? S_ARM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    judge_start_d = (state_d == S_ARM);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sum_q         <= '0;
      smp_cnt_q     <= '0;
      retry_q       <= '0;
      tmo_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dcnt_q        <= '0;
      judge_start_q <= 1'b0;
      freq_q        <= '0;
      freq_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      meas_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      smp_cnt_q     <= smp_cnt_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dcnt_q        <= dcnt_d;
      judge_start_q <= judge_start_d;
      freq_q        <= freq_d;
      freq_valid_q  <= freq_valid_d;
      busy_q        <= busy_d;
      meas_err_q    <= meas_err_d;
    end
  end

  assign bus.judge_start = judge_start_q;
  assign bus.freq        = freq_q;
  assign bus.freq_valid  = freq_valid_q;
  assign bus.busy        = busy_q;
  assign bus.meas_err    = meas_err_q;

endmodule
